// File: rtl/video_stream_timing.sv
// Video timing generator that paces an incoming pixel stream into the active area.
// Define VIDEO_STREAM_TIMING_PATTERN_EN to add a pattern_mode input that shows colour bars.
module video_stream_timing #(
  parameter int   HDISP  = 800,
  parameter int   VDISP  = 480,
  parameter int   HFP    = 40,
  parameter int   HPULSE = 48,
  parameter int   HBP    = 40,
  parameter int   VFP    = 13,
  parameter int   VPULSE = 3,
  parameter int   VBP    = 29,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int   DATA_W = 24
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_sof,
  input  logic                     err_clr,
`ifdef VIDEO_STREAM_TIMING_PATTERN_EN
  input  logic                     pattern_mode,
`endif
  output logic                     HS,
  output logic                     VS,
  output logic                     BLANK,
  output logic [DATA_W-1:0]        RGB,
  output logic [$clog2(HDISP)-1:0] pix_x,
  output logic [$clog2(VDISP)-1:0] pix_y,
  output logic                     locked,
  output logic                     underflow,
  output logic                     sync_err
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC0 = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC1 = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT   = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC0 = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC1 = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT   = VW'(VFP + VPULSE + VBP);

  // state | meaning
  // HUNT  | unaligned: drop non-SOF beats, wait for a SOF beat at frame origin
  // RUN   | aligned: exactly one beat consumed per active pixel
  typedef enum logic {HUNT, RUN} state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       h_cnt_q, h_cnt_d;
  logic [VW-1:0]       v_cnt_q, v_cnt_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                blank_q, blank_d;
  logic [DATA_W-1:0]   rgb_q, rgb_d;
  logic [XW-1:0]       pix_x_q, pix_x_d;
  logic [YW-1:0]       pix_y_q, pix_y_d;
  logic                underflow_q, underflow_d;
  logic                sync_err_q, sync_err_d;

  logic h_last, v_last, active, first_px, frame_org;
  logic ready_c, uf_set, se_set;

  always_comb begin
    h_last    = (h_cnt_q == H_LAST);
    v_last    = (v_cnt_q == V_LAST);
    h_cnt_d   = h_last ? '0 : h_cnt_q + HW'(1);
    v_cnt_d   = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    active    = (h_cnt_q >= H_ACT) && (v_cnt_q >= V_ACT);
    first_px  = (h_cnt_q == H_ACT) && (v_cnt_q == V_ACT);
    frame_org = (h_cnt_q == '0) && (v_cnt_q == '0);
    hs_d      = ((h_cnt_q >= H_SYNC0) && (h_cnt_q < H_SYNC1)) ? HS_POL : ~HS_POL;
    vs_d      = ((v_cnt_q >= V_SYNC0) && (v_cnt_q < V_SYNC1)) ? VS_POL : ~VS_POL;
    blank_d   = active;
    pix_x_d   = active ? XW'(h_cnt_q - H_ACT) : '0;
    pix_y_d   = active ? YW'(v_cnt_q - V_ACT) : '0;
  end

`ifdef VIDEO_STREAM_TIMING_PATTERN_EN
  localparam int CW = DATA_W / 3;
  logic [XW+2:0]     bar_num;
  logic [2:0]        bar_idx;
  logic [2:0]        bar_bits;
  logic [DATA_W-1:0] bar_rgb;

  // Bar order white..black; bits are {R,G,B} with each channel all-ones or zero.
  always_comb begin
    bar_num  = {pix_x_d, 3'b000};
    bar_idx  = 3'(32'(bar_num) / 32'(HDISP));
    bar_bits = 3'b000;
    case (bar_idx)
      3'd0:    bar_bits = 3'b111;
      3'd1:    bar_bits = 3'b110;
      3'd2:    bar_bits = 3'b011;
      3'd3:    bar_bits = 3'b010;
      3'd4:    bar_bits = 3'b101;
      3'd5:    bar_bits = 3'b100;
      3'd6:    bar_bits = 3'b001;
      default: bar_bits = 3'b000;
    endcase
    bar_rgb = '0;
    bar_rgb[DATA_W-1 -: CW]        = {CW{bar_bits[2]}};
    bar_rgb[DATA_W-1-CW -: CW]     = {CW{bar_bits[1]}};
    bar_rgb[DATA_W-1-2*CW -: CW]   = {CW{bar_bits[0]}};
  end
`endif

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    rgb_d   = '0;
    uf_set  = 1'b0;
    se_set  = 1'b0;
    case (state_q)
      HUNT: begin
        ready_c = s_valid & ~s_sof;
        if (frame_org && s_valid && s_sof) state_d = RUN;
      end
      RUN: begin
        if (active) begin
          ready_c = 1'b1;
          if (!s_valid) begin
            uf_set  = 1'b1;
            state_d = HUNT;
          end else begin
            rgb_d = s_data;
            if (s_sof != first_px) begin
              se_set  = 1'b1;
              state_d = HUNT;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
    underflow_d = uf_set | (underflow_q & ~err_clr);
    sync_err_d  = se_set | (sync_err_q & ~err_clr);
`ifdef VIDEO_STREAM_TIMING_PATTERN_EN
    if (pattern_mode) begin
      state_d     = state_q;
      ready_c     = 1'b0;
      rgb_d       = active ? bar_rgb : '0;
      underflow_d = underflow_q;
      sync_err_d  = sync_err_q;
    end
`endif
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q     <= HUNT;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign s_ready   = ready_c & ~pixel_rst;
  assign HS        = hs_q;
  assign VS        = vs_q;
  assign BLANK     = blank_q;
  assign RGB       = rgb_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign locked    = (state_q == RUN);
  assign underflow = underflow_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_video_stream_timing.sv
// Directed bench for video_stream_timing on a 7x5 pixel frame with a frame-position model.
module tb_video_stream_timing;

  localparam int  HDISP = 4, VDISP = 2;
  localparam int  HFP = 1, HPULSE = 1, HBP = 1;
  localparam int  VFP = 1, VPULSE = 1, VBP = 1;
  localparam bit  HS_POL = 1'b0, VS_POL = 1'b0;
  localparam int  HT = HFP + HPULSE + HBP + HDISP;
  localparam int  VT = VFP + VPULSE + VBP + VDISP;
  localparam int  HA = HFP + HPULSE + HBP;
  localparam int  VA = VFP + VPULSE + VBP;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        err_clr = 1'b0;
  logic        HS, VS, BLANK;
  logic [23:0] RGB;
  logic [1:0]  pix_x;
  logic [0:0]  pix_y;
  logic        locked, underflow, sync_err;

  video_stream_timing #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(HS_POL), .VS_POL(VS_POL), .DATA_W(24)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .err_clr(err_clr),
`ifdef VIDEO_STREAM_TIMING_PATTERN_EN
    .pattern_mode(1'b0),
`endif
    .HS(HS), .VS(VS), .BLANK(BLANK), .RGB(RGB), .pix_x(pix_x), .pix_y(pix_y),
    .locked(locked), .underflow(underflow), .sync_err(sync_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;

  logic [24:0] src_q[$];
  bit          src_en = 1'b0;

  int          m_n = 0;
  bit          m_locked, m_uf, m_se, chk_en, acc;
  bit          exp_hs, exp_vs, exp_blank, exp_locked, exp_uf, exp_se;
  logic [23:0] exp_rgb;
  int          exp_px, exp_py;

  logic [31:0] cap_rgb[$], cap_x[$], cap_y[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    if (src_en && src_q.size() > 0) begin
      s_valid = 1'b1;
      s_sof   = src_q[0][24];
      s_data  = src_q[0][23:0];
    end else begin
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = '0;
    end
  endtask

  // Frame position m_n is derived from cycles since reset; outputs lag it by one cycle.
  task automatic model_cycle();
    int h, v;
    bit act, first, er, uf_set, se_set;
    h     = m_n % HT;
    v     = m_n / HT;
    act   = (h >= HA) && (v >= VA);
    first = (h == HA) && (v == VA);
    if (pixel_rst)      er = 1'b0;
    else if (!m_locked) er = s_valid && !s_sof;
    else                er = act;
    if (chk_en) begin
      chk("HS", 32'(HS), 32'(exp_hs));
      chk("VS", 32'(VS), 32'(exp_vs));
      chk("BLANK", 32'(BLANK), 32'(exp_blank));
      chk("RGB", 32'(RGB), 32'(exp_rgb));
      chk("pix_x", 32'(pix_x), 32'(exp_px));
      chk("pix_y", 32'(pix_y), 32'(exp_py));
      chk("locked", 32'(locked), 32'(exp_locked));
      chk("underflow", 32'(underflow), 32'(exp_uf));
      chk("sync_err", 32'(sync_err), 32'(exp_se));
      chk("s_ready", 32'(s_ready), 32'(er));
    end
    acc = s_valid && s_ready;
    if (pixel_rst) begin
      exp_hs = !HS_POL; exp_vs = !VS_POL; exp_blank = 1'b0; exp_rgb = '0;
      exp_px = 0; exp_py = 0;
      m_locked = 1'b0; m_uf = 1'b0; m_se = 1'b0; m_n = 0; chk_en = 1'b1;
    end else begin
      uf_set    = 1'b0;
      se_set    = 1'b0;
      exp_hs    = (h >= HFP && h < HFP + HPULSE) ? HS_POL : !HS_POL;
      exp_vs    = (v >= VFP && v < VFP + VPULSE) ? VS_POL : !VS_POL;
      exp_blank = act;
      exp_px    = act ? h - HA : 0;
      exp_py    = act ? v - VA : 0;
      exp_rgb   = '0;
      if (!m_locked) begin
        if (m_n == 0 && s_valid && s_sof) m_locked = 1'b1;
      end else if (act) begin
        if (!s_valid) begin
          uf_set = 1'b1; m_locked = 1'b0;
        end else begin
          exp_rgb = s_data;
          if (bit'(s_sof) != first) begin
            se_set = 1'b1; m_locked = 1'b0;
          end
        end
      end
      m_uf = uf_set || (m_uf && !err_clr);
      m_se = se_set || (m_se && !err_clr);
      m_n  = (m_n + 1) % (HT * VT);
    end
    exp_locked = m_locked;
    exp_uf     = m_uf;
    exp_se     = m_se;
  endtask

  task automatic step();
    @(negedge pixel_clk);
    model_cycle();
    @(posedge pixel_clk);
    #1;
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    apply();
  endtask

  task automatic wait_pos(input int h, input int v);
    int k = 0;
    while (!((m_n % HT) == h && (m_n / HT) == v) && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) begin
      errors++;
      $display("FAIL wait_pos(%0d,%0d): position not reached in 200 cycles", h, v);
    end
  endtask

  task automatic push_beats(input logic [23:0] first, input int n, input int sof_idx);
    for (int i = 0; i < n; i++) src_q.push_back({(i == sof_idx), first + 24'(i)});
  endtask

  task automatic restart(input bit en);
    pixel_rst = 1'b1;
    step();
    src_q.delete();
    src_en = en;
  endtask

  initial begin
    int hs_lo, vs_lo, bl_hi, rgb_nz, lk;
    apply();
    repeat (3) step();

    // Idle timing, no stream
    pixel_rst = 1'b0;
    hs_lo = 0; vs_lo = 0; bl_hi = 0; rgb_nz = 0; lk = 0;
    repeat (35) begin
      step();
      hs_lo  += (HS == 1'b0) ? 1 : 0;
      vs_lo  += (VS == 1'b0) ? 1 : 0;
      bl_hi  += (BLANK == 1'b1) ? 1 : 0;
      rgb_nz += (RGB != '0) ? 1 : 0;
      lk     += (locked == 1'b1) ? 1 : 0;
    end
    chk("idle_hs_low_cycles", 32'(hs_lo), 32'd5);
    chk("idle_vs_low_cycles", 32'(vs_lo), 32'd7);
    chk("idle_blank_cycles", 32'(bl_hi), 32'd8);
    chk("idle_rgb_nonzero", 32'(rgb_nz), 32'd0);
    chk("idle_locked_cycles", 32'(lk), 32'd0);
    wait_pos(2, 0);
    chk("idle_hs_at_h1", 32'(HS), 32'd0);
    step();
    chk("idle_hs_at_h2", 32'(HS), 32'd1);
    wait_pos(3, 1);
    chk("idle_vs_at_v1", 32'(VS), 32'd0);

    // Clean 8-beat frame
    restart(1'b1);
    push_beats(24'h000001, 8, 0);
    apply();
    step();
    pixel_rst = 1'b0;
    apply();
    step();
    chk("lock_at_frame_start", 32'(locked), 32'd1);
    cap_rgb.delete(); cap_x.delete(); cap_y.delete();
    repeat (35) begin
      step();
      if (BLANK) begin
        cap_rgb.push_back(32'(RGB));
        cap_x.push_back(32'(pix_x));
        cap_y.push_back(32'(pix_y));
      end
    end
    chk("frame_pixel_count", 32'(cap_rgb.size()), 32'd8);
    for (int i = 0; i < 8 && i < cap_rgb.size(); i++) begin
      chk("frame_rgb", cap_rgb[i], 32'(i + 1));
      chk("frame_x", cap_x[i], 32'(i % 4));
      chk("frame_y", cap_y[i], 32'(i / 4));
    end
    chk("frame_underflow", 32'(underflow), 32'd0);
    chk("frame_sync_err", 32'(sync_err), 32'd0);
    chk("frame_locked", 32'(locked), 32'd1);

    // Underflow at pixel (2,1), then relock on the next SOF
    restart(1'b1);
    push_beats(24'h000001, 8, 0);
    push_beats(24'h000011, 8, 0);
    apply();
    step();
    pixel_rst = 1'b0;
    apply();
    wait_pos(5, 4);
    src_en = 1'b0;
    apply();
    step();
    src_en = 1'b1;
    apply();
    chk("uf_rgb", 32'(RGB), 32'd0);
    chk("uf_blank", 32'(BLANK), 32'd1);
    chk("uf_pix_x", 32'(pix_x), 32'd2);
    chk("uf_pix_y", 32'(pix_y), 32'd1);
    chk("uf_flag", 32'(underflow), 32'd1);
    chk("uf_locked", 32'(locked), 32'd0);
    wait_pos(4, 3);
    chk("uf_hunt_frame_rgb", 32'(RGB), 32'd0);
    chk("uf_hunt_frame_locked", 32'(locked), 32'd0);
    wait_pos(0, 0);
    wait_pos(4, 3);
    chk("relock_locked", 32'(locked), 32'd1);
    chk("relock_rgb", 32'(RGB), 32'h11);
    chk("relock_uf_sticky", 32'(underflow), 32'd1);

    // SOF on third beat, err_clr, err_clr coincident with a new error
    restart(1'b1);
    push_beats(24'h000001, 8, 0);
    src_q[2][24] = 1'b1;
    src_q.push_back({1'b1, 24'h000021});
    src_q.push_back({1'b1, 24'h000022});
    apply();
    step();
    pixel_rst = 1'b0;
    apply();
    wait_pos(6, 3);
    chk("se_rgb_shown", 32'(RGB), 32'd3);
    chk("se_flag", 32'(sync_err), 32'd1);
    chk("se_locked", 32'(locked), 32'd0);
    wait_pos(0, 4);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("se_cleared", 32'(sync_err), 32'd0);
    wait_pos(4, 3);
    chk("se_relock", 32'(locked), 32'd1);
    chk("se_relock_rgb", 32'(RGB), 32'h21);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("se_clr_collide", 32'(sync_err), 32'd1);
    chk("se_collide_locked", 32'(locked), 32'd0);
    chk("se_collide_rgb", 32'(RGB), 32'h22);
    chk("se_no_underflow", 32'(underflow), 32'd0);

    // Hunt: three non-SOF beats discarded, SOF held until frame origin
    restart(1'b1);
    apply();
    step();
    pixel_rst = 1'b0;
    apply();
    wait_pos(2, 1);
    push_beats(24'h000031, 3, 8);
    push_beats(24'h000034, 8, 0);
    apply();
    repeat (3) step();
    chk("hunt_discarded", 32'(src_q.size()), 32'd8);
    wait_pos(6, 4);
    chk("hunt_sof_held_ready", 32'(s_ready), 32'd0);
    chk("hunt_sof_held_count", 32'(src_q.size()), 32'd8);
    chk("hunt_not_locked", 32'(locked), 32'd0);
    wait_pos(4, 3);
    chk("hunt_lock", 32'(locked), 32'd1);
    chk("hunt_first_rgb", 32'(RGB), 32'h34);
    chk("hunt_consumed", 32'(src_q.size()), 32'd7);

    // Reset in the middle of an active line
    pixel_rst = 1'b1;
    apply();
    step();
    chk("rst_hs", 32'(HS), 32'd1);
    chk("rst_vs", 32'(VS), 32'd1);
    chk("rst_blank", 32'(BLANK), 32'd0);
    chk("rst_rgb", 32'(RGB), 32'd0);
    chk("rst_pix_x", 32'(pix_x), 32'd0);
    chk("rst_pix_y", 32'(pix_y), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    pixel_rst = 1'b0;
    apply();
    step();
    step();
    chk("rst_restart_hs", 32'(HS), 32'd0);
    chk("rst_restart_blank", 32'(BLANK), 32'd0);
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_stream_timing.md
VIDEO_STREAM_TIMING -- requirements
Module: video_stream_timing

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  HDISP 800 active pixels/line; VDISP 480 active lines; HFP 40, HPULSE 48, HBP 40 horizontal porches/sync (pixels); VFP 13, VPULSE 3, VBP 29 vertical porches/sync (lines); HS_POL 0 and VS_POL 0 sync active level; DATA_W 24 pixel width.
REQ-002 The block SHALL have one clock, pixel_clk; reset pixel_rst is synchronous and active-high.
REQ-003 Ports (name direction width meaning):
  pixel_clk in 1 pixel clock; pixel_rst in 1 sync reset, active-high;
  s_valid in 1 pixel beat valid; s_ready out 1 beat accepted when s_valid&s_ready; s_data in DATA_W pixel; s_sof in 1 beat is frame's first pixel;
  err_clr in 1 clears sticky flags; HS out 1; VS out 1; BLANK out 1 high in active area; RGB out DATA_W;
  pix_x out clog2(HDISP) column; pix_y out clog2(VDISP) line; locked out 1 state==RUN; underflow out 1 sticky; sync_err out 1 sticky.

Function
REQ-004 HTOTAL=HFP+HPULSE+HBP+HDISP, VTOTAL likewise; h_cnt counts 0..HTOTAL-1 and wraps to 0; v_cnt increments when h_cnt==HTOTAL-1, wraps to 0 after VTOTAL-1; counter widths clog2(HTOTAL), clog2(VTOTAL).
REQ-005 Region order per line/frame: front porch, sync, back porch, active; active = h_cnt>=HFP+HPULSE+HBP and v_cnt>=VFP+VPULSE+VBP.
REQ-006 HS SHALL equal HS_POL while HFP<=h_cnt<HFP+HPULSE, else !HS_POL; VS likewise on v_cnt with VS_POL.
REQ-007 HS, VS, BLANK, RGB, pix_x, pix_y SHALL be registered: one cycle latency after the counter value that decodes them.
REQ-008 States: HUNT, RUN. In HUNT: s_ready = s_valid & !s_sof (discard until a SOF beat is at head); BLANK still driven from timing; RGB=0.
REQ-009 HUNT->RUN at h_cnt==0 & v_cnt==0 when s_valid & s_sof; otherwise stay HUNT.
REQ-010 In RUN: s_ready=1 exactly on active counter positions; accepted s_data appears on RGB next cycle with BLANK=1.
REQ-011 RUN, active position, s_valid=0: RGB=0 next cycle, underflow<=1, state->HUNT.
REQ-012 RUN: accepted beat with s_sof=1 not at first active pixel, or s_sof=0 at first active pixel: pixel still displayed, sync_err<=1, state->HUNT.
REQ-013 pix_x/pix_y SHALL be active-area coordinates when BLANK=1, 0 otherwise.
REQ-014 err_clr clears underflow and sync_err; a new error in the same cycle wins (flag stays 1).
REQ-015 Outside the active area RGB SHALL be 0.

Reset
REQ-016 pixel_rst SHALL force h_cnt=0, v_cnt=0, state HUNT, HS=!HS_POL, VS=!VS_POL, BLANK=0, RGB=0, pix_x=0, pix_y=0, locked=0, underflow=0, sync_err=0; mid-frame reset restarts timing from counter 0 on the cycle after release.
REQ-017 s_ready SHALL be 0 while pixel_rst=1.

Configuration
REQ-018 Macro VIDEO_STREAM_TIMING_PATTERN_EN: when defined, input pattern_mode (1 bit) is added; pattern_mode=1 forces RGB to 8 vertical colour bars (bar = pix_x*8/HDISP, colours white, yellow, cyan, green, magenta, red, blue, black, per-channel 0 or all-ones), s_ready=0, no flag updates, state frozen; when undefined, the port and logic are absent and behaviour is REQ-008..REQ-015 only.

Verification (HDISP=4, VDISP=2, all porches/pulses=1: HTOTAL=7, VTOTAL=5, 35-cycle frame)
REQ-019 Release reset, s_valid=0 -> HS low exactly for h_cnt=1 (output cycle 2 of each line), VS low for v_cnt=1, BLANK high 4 cycles on lines 3,4, locked=0, RGB=0.
REQ-020 Stream of 8 beats 0x000001..0x000008, SOF on first, held valid from reset -> locked=1 at frame start, RGB shows 1..4 then 5..8 with BLANK=1, pix_x 0..3, pix_y 0,1; no flags.
REQ-021 Locked, drop s_valid at pixel (2,1) -> RGB=0 that cycle, underflow=1, locked=0; re-lock on next SOF at frame start.
REQ-022 Locked, SOF on third beat -> sync_err=1, locked=0; err_clr pulse -> sync_err=0; err_clr coincident with new error -> flag stays 1.
REQ-023 In HUNT feed 3 non-SOF beats then SOF -> the 3 beats accepted/discarded, SOF beat held until h_cnt=v_cnt=0.
REQ-024 Assert pixel_rst mid-active-line -> all outputs at REQ-016 values next cycle; timing restarts from 0.
